// File: rtl/time_set_ctrl_if.sv
// Front-panel signal bundle between the board keys/prescaler and the time/alarm datapath.
// slave is the controller side, master is the side that drives keys and ticks.
interface time_set_ctrl_if;
   logic       KeyMode;
   logic       KeyInc;
   logic       Tick1Hz;
   logic [2:0] Mode;
   logic       CountEN;
   logic       SelAlarm;
   logic       IncH;
   logic       IncM;
   logic       IncAH;
   logic       IncAM;
   logic       ClrSec;

   modport slave (
      input  KeyMode, KeyInc, Tick1Hz,
      output Mode, CountEN, SelAlarm, IncH, IncM, IncAH, IncAM, ClrSec
   );

   modport master (
      output KeyMode, KeyInc, Tick1Hz,
      input  Mode, CountEN, SelAlarm, IncH, IncM, IncAH, IncAM, ClrSec
   );
endinterface

// File: rtl/time_set_ctrl.sv
// Time/alarm edit controller: debounced Mode/Inc keys, 5-state edit FSM, increment strobes
// with hold-to-auto-repeat, idle timeout back to RUN and seconds-clear on leaving SET_M.
module time_set_ctrl #(
   parameter int unsigned DEB_CYCLES  = 1_000_000,
   parameter int unsigned HOLD_CYCLES = 25_000_000,
   parameter int unsigned REP_CYCLES  = 10_000_000,
   parameter int unsigned TIMEOUT_S   = 30,
   parameter int unsigned CNT_W       = 25
) (
   input  logic           CP50,
   input  logic           nCR,
   time_set_ctrl_if.slave panel
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_S + 1);

   typedef enum logic [2:0] {
      StRun   = 3'd0,
      StSetH  = 3'd1,
      StSetM  = 3'd2,
      StSetAh = 3'd3,
      StSetAm = 3'd4
   } state_e;

   // Index 0 is the Mode key, index 1 the Inc key.
   logic [1:0]            key_raw;
   logic [1:0]            s1_q, s2_q, db_q, db_last_q;
   logic [1:0][CNT_W-1:0] deb_cnt_q;
   logic [1:0]            press;
   logic                  mode_press, inc_press;

   state_e          state_q, state_d, state_adv;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            rep_act_q, rep_act_d;
   logic            rep_first_q, rep_first_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic            edit, stb, timeout;
   logic [3:0]      inc_d, inc_q;
   logic            clr_d, clr_q;
   logic            counten_q, selalarm_q;

   assign key_raw    = {panel.KeyInc, panel.KeyMode};
   assign press      = db_q & ~db_last_q;
   assign mode_press = press[0];
   assign inc_press  = press[1];

   always_ff @(posedge CP50 or negedge nCR) begin
      if (!nCR) begin
         s1_q      <= '0;
         s2_q      <= '0;
         db_q      <= '0;
         db_last_q <= '0;
         deb_cnt_q <= '0;
      end else begin
         s1_q      <= key_raw;
         s2_q      <= s1_q;
         db_last_q <= db_q;
         for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == db_q[i]) begin
               deb_cnt_q[i] <= '0;
            end else if (deb_cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
               db_q[i]      <= s2_q[i];
               deb_cnt_q[i] <= '0;
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      state_adv   = StRun;
      to_cnt_d    = to_cnt_q;
      rep_act_d   = rep_act_q;
      rep_first_d = rep_first_q;
      rep_cnt_d   = rep_cnt_q;
      stb         = 1'b0;
      inc_d       = '0;
      edit        = (state_q != StRun);

      unique case (state_q)
         StRun:   state_adv = StSetH;
         StSetH:  state_adv = StSetM;
         StSetM:  state_adv = StSetAh;
         StSetAh: state_adv = StSetAm;
         default: state_adv = StRun;
      endcase

      // A press on the same cycle as the final tick keeps the edit mode alive.
      timeout = edit && panel.Tick1Hz && !inc_press && (to_cnt_q == TO_W'(TIMEOUT_S - 1));

      if (mode_press) begin
         state_d = state_adv;
      end else if (timeout) begin
         state_d = StRun;
      end

      if (state_d != state_q || mode_press || inc_press) begin
         to_cnt_d = '0;
      end else if (edit && panel.Tick1Hz) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end

      if (inc_press) begin
         stb         = edit;
         rep_act_d   = edit;
         rep_first_d = 1'b1;
         rep_cnt_d   = '0;
      end else if (rep_act_q) begin
         if (!db_q[1]) begin
            rep_act_d = 1'b0;
         end else if (rep_first_q ? (rep_cnt_q == CNT_W'(HOLD_CYCLES - 1))
                                  : (rep_cnt_q == CNT_W'(REP_CYCLES - 1))) begin
            stb         = 1'b1;
            rep_first_d = 1'b0;
            rep_cnt_d   = '0;
         end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
         end
      end

      // Any state change kills both the pending strobe and the repeat; a held key must re-press.
      if (state_d != state_q) begin
         stb       = 1'b0;
         rep_act_d = 1'b0;
      end

      if (stb) begin
         unique case (state_q)
            StSetH:  inc_d = 4'b0001;
            StSetM:  inc_d = 4'b0010;
            StSetAh: inc_d = 4'b0100;
            StSetAm: inc_d = 4'b1000;
            default: inc_d = 4'b0000;
         endcase
      end

      clr_d = (state_q == StSetM) && (state_d != StSetM);
   end

   always_ff @(posedge CP50 or negedge nCR) begin
      if (!nCR) begin
         state_q     <= StRun;
         to_cnt_q    <= '0;
         rep_act_q   <= 1'b0;
         rep_first_q <= 1'b0;
         rep_cnt_q   <= '0;
         inc_q       <= '0;
         clr_q       <= 1'b0;
         counten_q   <= 1'b1;
         selalarm_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         to_cnt_q    <= to_cnt_d;
         rep_act_q   <= rep_act_d;
         rep_first_q <= rep_first_d;
         rep_cnt_q   <= rep_cnt_d;
         inc_q       <= inc_d;
         clr_q       <= clr_d;
         counten_q   <= !(state_d == StSetH || state_d == StSetM);
         selalarm_q  <= (state_d == StSetAh || state_d == StSetAm);
      end
   end

   assign panel.Mode     = state_q;
   assign panel.CountEN  = counten_q;
   assign panel.SelAlarm = selalarm_q;
   assign panel.IncH     = inc_q[0];
   assign panel.IncM     = inc_q[1];
   assign panel.IncAH    = inc_q[2];
   assign panel.IncAM    = inc_q[3];
   assign panel.ClrSec   = clr_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed edit/repeat/timeout/reset steps, then
// randomized key sequences checked against an event-time model of the panel behaviour.
module tb_time_set_ctrl;

   localparam int DEB  = 4;
   localparam int HOLD = 20;
   localparam int REP  = 5;
   localparam int TMO  = 3;
   localparam int LAT  = DEB + 3;

   logic CP50 = 1'b0;
   logic nCR;

   time_set_ctrl_if panel ();

   time_set_ctrl #(
      .DEB_CYCLES  (DEB),
      .HOLD_CYCLES (HOLD),
      .REP_CYCLES  (REP),
      .TIMEOUT_S   (TMO),
      .CNT_W       (25)
   ) dut (
      .CP50  (CP50),
      .nCR   (nCR),
      .panel (panel)
   );

   always #5 CP50 = ~CP50;

   int vectors     = 0;
   int miscompares = 0;
   int exp_mode    = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outs(input logic [3:0] exp_stb, input logic exp_clr);
      chk("Mode", 8'(panel.Mode), 8'(exp_mode));
      chk("CountEN", 8'(panel.CountEN), (exp_mode == 1 || exp_mode == 2) ? 8'd0 : 8'd1);
      chk("SelAlarm", 8'(panel.SelAlarm), (exp_mode == 3 || exp_mode == 4) ? 8'd1 : 8'd0);
      chk("IncStrobes", 8'({panel.IncAM, panel.IncAH, panel.IncM, panel.IncH}), 8'(exp_stb));
      chk("ClrSec", 8'(panel.ClrSec), 8'(exp_clr));
   endtask

   task automatic step(input logic [3:0] exp_stb, input logic exp_clr);
      @(posedge CP50);
      #1;
      check_outs(exp_stb, exp_clr);
   endtask

   // Strobe cycles (counted from the first edge sampling the key high) for an Inc hold of ih cycles.
   function automatic bit rep_hit(input int k, input int ih);
      if (k > ih + 6) return 1'b0;
      if (k == LAT) return 1'b1;
      return (k >= LAT + HOLD) && ((k - (LAT + HOLD)) % REP == 0);
   endfunction

   function automatic logic [3:0] stb_for(input int m);
      return (m == 0) ? 4'b0000 : 4'(4'b0001 << (m - 1));
   endfunction

   // Both keys rise together; Mode held mh cycles, Inc held ih cycles, n cycles checked.
   task automatic run_keys(input int mh, input int ih, input int n);
      bit         mode_ev;
      bit         inc_ev;
      logic [3:0] stb;
      logic       clr;
      mode_ev = (mh >= DEB);
      inc_ev  = (ih >= DEB) && !mode_ev;
      for (int k = 1; k <= n; k++) begin
         panel.KeyMode = (k <= mh);
         panel.KeyInc  = (k <= ih);
         stb = '0;
         clr = 1'b0;
         if (mode_ev && k == LAT) begin
            clr      = (exp_mode == 2);
            exp_mode = (exp_mode + 1) % 5;
         end
         if (inc_ev && rep_hit(k, ih)) stb = stb_for(exp_mode);
         step(stb, clr);
      end
      panel.KeyMode = 1'b0;
      panel.KeyInc  = 1'b0;
   endtask

   task automatic tick(input int mode_after);
      panel.Tick1Hz = 1'b1;
      exp_mode      = mode_after;
      step(4'b0000, 1'b0);
      panel.Tick1Hz = 1'b0;
   endtask

   initial begin
      int m;
      int mh;
      int ih;
      panel.KeyMode = 1'b0;
      panel.KeyInc  = 1'b0;
      panel.Tick1Hz = 1'b0;
      nCR = 1'b1;
      #2 nCR = 1'b0;
      #1 check_outs(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      nCR = 1'b1;
      step(4'b0000, 1'b0);

      // RUN -> SET_H
      run_keys(10, 0, 20);

      // Bouncing Inc never debounces, then a clean press gives one IncH.
      for (int k = 0; k < 20; k++) begin
         panel.KeyInc = ((k / 2) % 2 == 0);
         step(4'b0000, 1'b0);
      end
      panel.KeyInc = 1'b0;
      for (int k = 0; k < 10; k++) step(4'b0000, 1'b0);
      run_keys(0, 10, 20);

      // SET_M with auto-repeat, then exit with ClrSec.
      run_keys(10, 0, 20);
      run_keys(0, 50, 60);
      run_keys(10, 0, 20);
      run_keys(10, 0, 20);
      run_keys(10, 0, 20);
      run_keys(0, 10, 20);

      // Timeout from SET_AH.
      run_keys(10, 0, 20);
      run_keys(10, 0, 20);
      run_keys(10, 0, 20);
      tick(3);
      step(4'b0000, 1'b0);
      tick(3);
      step(4'b0000, 1'b0);
      tick(0);
      for (int k = 0; k < 5; k++) step(4'b0000, 1'b0);

      // Mode and Inc together: mode wins, no IncH.
      run_keys(10, 10, 25);

      // Reset during auto-repeat in SET_AM.
      run_keys(10, 0, 20);
      run_keys(10, 0, 20);
      run_keys(10, 0, 20);
      for (int k = 1; k <= 30; k++) begin
         panel.KeyInc = 1'b1;
         step(rep_hit(k, 1000) ? stb_for(exp_mode) : 4'b0000, 1'b0);
      end
      #3 nCR = 1'b0;
      exp_mode = 0;
      #1 check_outs(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      nCR = 1'b1;
      for (int k = 0; k < 20; k++) step(4'b0000, 1'b0);
      panel.KeyInc = 1'b0;
      for (int k = 0; k < 10; k++) step(4'b0000, 1'b0);

      // Randomized mode walks followed by Inc holds of random length.
      for (int it = 0; it < 12; it++) begin
         m = $urandom_range(0, 2);
         for (int j = 0; j < m; j++) begin
            mh = $urandom_range(DEB, 12);
            run_keys(mh, 0, mh + 10);
         end
         ih = $urandom_range(DEB, 60);
         run_keys(0, ih, ih + 10);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
